// File: rtl/trace_bp_buffer.sv
// rtl/trace_bp_buffer.sv - backpressure queue between trace sampler and trace FIFO
// Non-stallable source: overflow losses are counted and reported by one marker packet.
module trace_bp_buffer #(
  parameter int sample_width_p  = 16,
  parameter int counter_width_p = 16,
  parameter int depth_p         = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [sample_width_p-1:0]   sample_data,
  input  logic                        sample_valid,
  output logic [sample_width_p:0]     fifo_data,
  output logic                        fifo_valid,
  input  logic                        fifo_ready,
  output logic [counter_width_p-1:0]  drop_total
);

  localparam int ptr_w = $clog2(depth_p);
  localparam int out_w = sample_width_p + 1;

  typedef enum logic {PASS, DROP} state_t;

  state_t                     state, state_next;
  logic [out_w-1:0]           mem [depth_p];
  logic [ptr_w-1:0]           wr_ptr, rd_ptr;
  logic [ptr_w:0]             count;
  logic [counter_width_p-1:0] ctr, ctr_next, cnt_now;
  logic                       empty, full, pop, space, push, drop;
  logic [out_w-1:0]           push_data;

  assign empty      = (count == '0);
  assign full       = (count == (ptr_w+1)'(depth_p));
  assign fifo_valid = !empty;
  assign fifo_data  = empty ? '0 : mem[rd_ptr];
  assign pop        = fifo_valid && fifo_ready;
  // A pop in the same cycle frees the slot a push needs.
  assign space      = !full || pop;

  always_comb begin
    state_next = state;
    ctr_next   = ctr;
    push       = 1'b0;
    push_data  = '0;
    drop       = 1'b0;
    cnt_now    = (&ctr) ? ctr : ctr + counter_width_p'(sample_valid);
    case (state)
      PASS: begin
        if (sample_valid) begin
          if (space) begin
            push      = 1'b1;
            push_data = {1'b0, sample_data};
          end else begin
            drop       = 1'b1;
            ctr_next   = counter_width_p'(1);
            state_next = DROP;
          end
        end
      end
      DROP: begin
        // The marker claims the free slot, so any sample this cycle is lost too.
        drop = sample_valid;
        if (space) begin
          push       = 1'b1;
          push_data  = {1'b1, sample_width_p'(cnt_now)};
          ctr_next   = '0;
          state_next = PASS;
        end else begin
          ctr_next = cnt_now;
        end
      end
      default: state_next = PASS;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= PASS;
      ctr        <= '0;
      drop_total <= '0;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
    end else begin
      state <= state_next;
      ctr   <= ctr_next;
      if (drop && !(&drop_total))
        drop_total <= drop_total + 1'b1;
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: fifo_data is masked while the queue is empty.
  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

endmodule

// File: tb/tb_trace_bp_buffer.sv
// tb/tb_trace_bp_buffer.sv - directed self-checking bench for trace_bp_buffer
module tb_trace_bp_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic [16:0] fifo_data;
  logic        fifo_valid;
  logic        fifo_ready;
  logic [15:0] drop_total;

  logic [15:0] s4_data;
  logic        s4_valid;
  logic [16:0] f4_data;
  logic        f4_valid;
  logic        f4_ready;
  logic [3:0]  d4_total;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trace_bp_buffer dut (
    .clk(clk), .rst(rst),
    .sample_data(sample_data), .sample_valid(sample_valid),
    .fifo_data(fifo_data), .fifo_valid(fifo_valid), .fifo_ready(fifo_ready),
    .drop_total(drop_total)
  );

  trace_bp_buffer #(.counter_width_p(4)) dut4 (
    .clk(clk), .rst(rst),
    .sample_data(s4_data), .sample_valid(s4_valid),
    .fifo_data(f4_data), .fifo_valid(f4_valid), .fifo_ready(f4_ready),
    .drop_total(d4_total)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp2 [5];
    logic [31:0] exp4 [4];
    logic [31:0] exp5 [4];

    rst = 1'b1; sample_data = '0; sample_valid = 1'b0; fifo_ready = 1'b0;
    s4_data = '0; s4_valid = 1'b0; f4_ready = 1'b0;
    tick(); tick();
    check("rst_valid", 32'(fifo_valid), 0);
    check("rst_data", 32'(fifo_data), 0);
    check("rst_drop", 32'(drop_total), 0);
    rst = 1'b0;

    // 1: streaming, one cycle latency, no marker
    fifo_ready = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      sample_data = 16'(i); sample_valid = 1'b1;
      tick();
      check("t1_valid", 32'(fifo_valid), 1);
      check("t1_data", 32'(fifo_data), 32'(i));
    end
    sample_valid = 1'b0;
    tick();
    check("t1_empty", 32'(fifo_valid), 0);
    check("t1_zero", 32'(fifo_data), 0);
    check("t1_drop", 32'(drop_total), 0);

    // 2: seven samples into a stalled depth-4 queue
    fifo_ready = 1'b0;
    for (int i = 0; i < 7; i++) begin
      sample_data = 16'hA0 + 16'(i); sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("t2_drop", 32'(drop_total), 3);
    fifo_ready = 1'b1;
    exp2 = '{32'hA0, 32'hA1, 32'hA2, 32'hA3, 32'h10003};
    for (int k = 0; k < 5; k++) begin
      check("t2_out", 32'(fifo_data), exp2[k]);
      tick();
    end
    check("t2_empty", 32'(fifo_valid), 0);

    // 4: DROP with ctr=2, pop and sample in the same cycle
    fifo_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      sample_data = 16'hB0 + 16'(i); sample_valid = 1'b1;
      tick();
    end
    check("t4_drop_pre", 32'(drop_total), 5);
    sample_data = 16'hB6; fifo_ready = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("t4_drop_post", 32'(drop_total), 6);
    exp4 = '{32'hB1, 32'hB2, 32'hB3, 32'h10003};
    for (int k = 0; k < 4; k++) begin
      check("t4_out", 32'(fifo_data), exp4[k]);
      tick();
    end
    check("t4_empty", 32'(fifo_valid), 0);
    sample_data = 16'hBB; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("t4_pass", 32'(fifo_data), 32'hBB);
    tick();

    // 5: full in PASS, pop and push together
    fifo_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      sample_data = 16'hC0 + 16'(i); sample_valid = 1'b1;
      tick();
    end
    sample_data = 16'hC4; fifo_ready = 1'b1;
    tick();
    sample_valid = 1'b0;
    check("t5_drop", 32'(drop_total), 6);
    exp5 = '{32'hC1, 32'hC2, 32'hC3, 32'hC4};
    for (int k = 0; k < 4; k++) begin
      check("t5_out", 32'(fifo_data), exp5[k]);
      tick();
    end
    check("t5_empty", 32'(fifo_valid), 0);

    // 6: reset in DROP with ctr=5
    fifo_ready = 1'b0;
    for (int i = 0; i < 9; i++) begin
      sample_data = 16'hD0 + 16'(i); sample_valid = 1'b1;
      tick();
    end
    sample_valid = 1'b0;
    check("t6_drop_pre", 32'(drop_total), 11);
    rst = 1'b1;
    tick();
    check("t6_valid", 32'(fifo_valid), 0);
    check("t6_drop", 32'(drop_total), 0);
    rst = 1'b0; fifo_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick();
      check("t6_nomark", 32'(fifo_valid), 0);
    end

    // 3: 4-bit loss counter saturates
    f4_ready = 1'b0;
    for (int i = 0; i < 24; i++) begin
      s4_data = 16'hE0 + 16'(i); s4_valid = 1'b1;
      tick();
    end
    s4_valid = 1'b0;
    check("t3_drop", 32'(d4_total), 32'hF);
    f4_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      check("t3_out", 32'(f4_data), 32'hE0 + 32'(k));
      tick();
    end
    check("t3_marker", 32'(f4_data), 32'h1000F);
    tick();
    check("t3_empty", 32'(f4_valid), 0);
    check("t3_drop_end", 32'(d4_total), 32'hF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
